// File: rtl/qif_pkg.sv
`default_nettype none
// ==== qif_pkg : shared scheduler state encoding, default sizes and clog2 helper | rev 1.0 ====
package qif_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam int c_DEF_NUM_NEURONS = 4;
  localparam int c_DEF_V_W         = 8;
  localparam int c_DEF_B_W         = 8;
  localparam int c_DEF_TICK_DIV    = 64;
  localparam int c_DEF_EV_DEPTH    = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qif_neuron_scheduler_if.sv
`default_nettype none
// ==== qif_neuron_scheduler_if : datapath launch/result and spike-event stream | rev 1.0 ====
interface qif_neuron_scheduler_if
  import qif_pkg::*;
#(
  parameter int V_W   = c_DEF_V_W,
  parameter int B_W   = c_DEF_B_W,
  parameter int IDX_W = clog2(c_DEF_NUM_NEURONS)
);
  logic             dp_start;
  logic [V_W-1:0]   dp_v;
  logic [B_W-1:0]   dp_b;
  logic             dp_done;
  logic [V_W-1:0]   dp_v_next;
  logic             dp_spike;
  logic             ev_valid;
  logic [IDX_W-1:0] ev_idx;
  logic             ev_ready;

  modport master (
    output dp_start, dp_v, dp_b, ev_valid, ev_idx,
    input  dp_done, dp_v_next, dp_spike, ev_ready
  );

  modport slave (
    input  dp_start, dp_v, dp_b, ev_valid, ev_idx,
    output dp_done, dp_v_next, dp_spike, ev_ready
  );
endinterface
`default_nettype wire

// File: rtl/qif_event_fifo.sv
`default_nettype none
// ==== qif_event_fifo : synchronous FIFO; a push into a full FIFO survives only with a same-cycle pop | rev 1.0 ====
module qif_event_fifo
  import qif_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = c_DEF_EV_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             drop
);
  localparam int c_AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign drop      = push && full && !w_do_pop;
  // Head is forced to zero when empty so stale storage never leaks out.
  assign head      = empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
  end
endmodule
`default_nettype wire

// File: rtl/qif_neuron_scheduler.sv
`default_nettype none
// ==== qif_neuron_scheduler : sweeps NUM_NEURONS virtual QIF neurons through one shared datapath per tick | rev 1.0 ====
module qif_neuron_scheduler
  import qif_pkg::*;
#(
  parameter int NUM_NEURONS = c_DEF_NUM_NEURONS,
  parameter int V_W         = c_DEF_V_W,
  parameter int B_W         = c_DEF_B_W,
  parameter int TICK_DIV    = c_DEF_TICK_DIV,
  parameter int EV_DEPTH    = c_DEF_EV_DEPTH,
  localparam int IDX_W      = clog2(NUM_NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr_flags,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [B_W-1:0]        cfg_b,
  qif_neuron_scheduler_if.master bus,
  output logic                  busy,
  output logic                  tick_miss,
  output logic                  ev_drop
);
  localparam int                 c_CNT_W   = clog2(TICK_DIV);
  localparam logic [IDX_W-1:0]   c_LAST    = IDX_W'(NUM_NEURONS - 1);
  localparam logic [c_CNT_W-1:0] c_TICK_AT = c_CNT_W'(TICK_DIV - 1);

  state_t             r_state;
  state_t             w_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [V_W-1:0]     r_v [NUM_NEURONS];
  logic [B_W-1:0]     r_b [NUM_NEURONS];
  logic [V_W-1:0]     r_dp_v;
  logic [B_W-1:0]     r_dp_b;
  logic               r_tick_miss;
  logic               r_ev_drop;
  logic               w_tick;
  logic               w_last;
  logic               w_load;
  logic [IDX_W-1:0]   w_load_idx;
  logic               w_capture;
  logic               w_push;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_fifo_drop;
  logic [IDX_W-1:0]   w_fifo_head;

  assign w_tick    = en && (r_cnt == c_TICK_AT);
  assign w_last    = (r_idx == c_LAST);
  assign w_capture = (r_state == WAIT) && bus.dp_done;
  assign w_push    = w_capture && bus.dp_spike;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_cnt <= '0;
    else if (en) r_cnt <= w_tick ? '0 : r_cnt + c_CNT_W'(1);
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_idx = '0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_next = ISSUE;
          w_load = 1'b1;
        end
      end
      ISSUE: w_next = WAIT;
      WAIT:  if (bus.dp_done) w_next = WB;
      WB: begin
        if (w_last) begin
          w_next = IDLE;
        end else begin
          w_next     = ISSUE;
          w_load     = 1'b1;
          w_load_idx = r_idx + IDX_W'(1);
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand load reads r_b before any same-edge cfg write lands, so that write waits a sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_dp_v  <= '0;
      r_dp_b  <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_v[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_dp_v <= r_v[w_load_idx];
        r_dp_b <= r_b[w_load_idx];
      end
      if (w_capture)         r_v[r_idx] <= bus.dp_v_next;
      if (r_state == WB)     r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      if (cfg_we)            r_b[cfg_idx] <= cfg_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_miss <= 1'b0;
      r_ev_drop   <= 1'b0;
    end else begin
      if (w_tick && (r_state != IDLE)) r_tick_miss <= 1'b1;
      else if (clr_flags)              r_tick_miss <= 1'b0;
      if (w_fifo_drop)                 r_ev_drop <= 1'b1;
      else if (clr_flags)              r_ev_drop <= 1'b0;
    end
  end

  qif_event_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (EV_DEPTH)
  ) u_ev_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (r_idx),
    .pop       (bus.ev_ready),
    .head      (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .drop      (w_fifo_drop)
  );

  assign bus.dp_start = (r_state == ISSUE);
  assign bus.dp_v     = r_dp_v;
  assign bus.dp_b     = r_dp_b;
  assign bus.ev_valid = !w_fifo_empty;
  assign bus.ev_idx   = w_fifo_head;
  assign busy         = (r_state != IDLE);
  assign tick_miss    = r_tick_miss;
  assign ev_drop      = r_ev_drop;
endmodule
`default_nettype wire

// File: tb/tb_qif_neuron_scheduler.sv
`default_nettype none
// ==== tb_qif_neuron_scheduler : sweep table plus datapath model and event scoreboard | rev 1.0 ====
module tb_qif_neuron_scheduler;
  import qif_pkg::*;

  localparam int N        = 4;
  localparam int V_W      = 8;
  localparam int B_W      = 8;
  localparam int TICK_DIV = 64;
  localparam int EV_DEPTH = 4;
  localparam int IDX_W    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             clr_flags = 1'b0;
  logic             cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_idx = '0;
  logic [B_W-1:0]   cfg_b = '0;
  logic             busy;
  logic             tick_miss;
  logic             ev_drop;

  qif_neuron_scheduler_if #(.V_W(V_W), .B_W(B_W), .IDX_W(IDX_W)) bus ();

  qif_neuron_scheduler #(
    .NUM_NEURONS (N),
    .V_W         (V_W),
    .B_W         (B_W),
    .TICK_DIV    (TICK_DIV),
    .EV_DEPTH    (EV_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr_flags (clr_flags),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_b     (cfg_b),
    .bus       (bus),
    .busy      (busy),
    .tick_miss (tick_miss),
    .ev_drop   (ev_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    int          lat;
    bit          ready;
    bit          race;
    int          period;
    bit          exp_miss;
    logic [31:0] v;
    logic [31:0] b;
  } vec_t;

  vec_t             tbl [9];
  int unsigned      nvec = 0;
  int unsigned      nerr = 0;
  int               cyc = 0;
  int               last_first = 0;
  int               lat = 2;
  logic [3:0]       mask = '0;
  logic [IDX_W-1:0] exp_q [$];
  bit               exp_drop = 1'b0;
  int               m_n = 0;
  int               m_cnt = 0;
  bit               m_pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] q4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic vec_t mk(input logic [3:0] m, input int l, input bit rdy, input bit race,
                              input int period, input bit miss, input logic [31:0] v,
                              input logic [31:0] b);
    vec_t e;
    e.mask = m; e.lat = l; e.ready = rdy; e.race = race;
    e.period = period; e.exp_miss = miss; e.v = v; e.b = b;
    return e;
  endfunction

  // Datapath (v_next = v + b after lat cycles) and event consumer/scoreboard, driven off the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      m_n = 0; m_pend = 1'b0; exp_q.delete(); exp_drop = 1'b0;
      bus.dp_done = 1'b0; bus.dp_spike = 1'b0;
    end else begin
      if (bus.ev_valid && bus.ev_ready) begin
        if (exp_q.size() == 0) check("ev_unexpected", 1, 0);
        else begin
          check("ev_idx", bus.ev_idx, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
      bus.dp_done = 1'b0;
      bus.dp_spike = 1'b0;
      if (bus.dp_start) begin
        m_pend = 1'b1;
        m_cnt  = lat - 1;
      end else if (m_pend) begin
        if (m_cnt == 0) begin
          bus.dp_done   = 1'b1;
          bus.dp_v_next = bus.dp_v + bus.dp_b;
          bus.dp_spike  = mask[m_n];
          if (mask[m_n]) begin
            if (exp_q.size() < EV_DEPTH) exp_q.push_back(IDX_W'(m_n));
            else exp_drop = 1'b1;
          end
          m_n    = (m_n + 1) % N;
          m_pend = 1'b0;
        end else begin
          m_cnt--;
        end
      end
    end
  end

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (bus.dp_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("start_timeout", 0, 1);
  endtask

  task automatic run_sweep(input vec_t e);
    bit ok;
    int extra;
    lat = e.lat;
    mask = e.mask;
    bus.ev_ready = e.ready;
    clr_flags = 1'b1;
    exp_drop = 1'b0;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    for (int n = 0; n < N; n++) begin
      if (e.race && n == 2) check("race_start", bus.dp_start, 1);
      else wait_start(ok);
      if (n == 0) begin
        if (e.period != 0) check("tick_period", cyc - last_first, e.period);
        last_first = cyc;
      end
      check("dp_v", bus.dp_v, e.v[8*n +: 8]);
      check("dp_b", bus.dp_b, e.b[8*n +: 8]);
      if (e.race && n == 1) begin
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(posedge clk); #1;
          if (bus.dp_done) begin
            ok = 1'b1;
            break;
          end
        end
        check("race_wb_seen", ok, 1);
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_b = 8'd50;
        @(posedge clk); #1;
        cfg_we = 1'b0;
      end
    end
    extra = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (bus.dp_start) extra++;
      if (!busy) break;
    end
    check("extra_start", extra, 0);
    check("busy_end", busy, 0);
    check("tick_miss", tick_miss, e.exp_miss);
    check("ev_drop", ev_drop, exp_drop);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    tbl[0] = mk(4'b0000, 2,  1, 0, 0,   0, q4(0, 0, 0, 0),      q4(5, 6, 7, 8));
    tbl[1] = mk(4'b1010, 2,  1, 0, 64,  0, q4(5, 6, 7, 8),      q4(5, 6, 7, 8));
    tbl[2] = mk(4'b1111, 2,  0, 0, 64,  0, q4(10, 12, 14, 16),  q4(5, 6, 7, 8));
    tbl[3] = mk(4'b1111, 2,  0, 0, 64,  0, q4(15, 18, 21, 24),  q4(5, 6, 7, 8));
    tbl[4] = mk(4'b0000, 2,  1, 1, 64,  0, q4(20, 24, 28, 32),  q4(5, 6, 7, 8));
    tbl[5] = mk(4'b0000, 2,  1, 0, 64,  0, q4(25, 30, 35, 40),  q4(5, 6, 50, 8));
    tbl[6] = mk(4'b0000, 20, 1, 0, 64,  1, q4(30, 36, 85, 48),  q4(5, 6, 50, 8));
    tbl[7] = mk(4'b0000, 2,  1, 0, 128, 0, q4(35, 42, 135, 56), q4(5, 6, 50, 8));
    tbl[8] = mk(4'b0001, 2,  1, 0, 0,   0, q4(0, 0, 0, 0),      q4(0, 0, 0, 0));

    bus.dp_done = 1'b0; bus.dp_spike = 1'b0; bus.dp_v_next = '0; bus.ev_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_dp_start", bus.dp_start, 0);
    check("rst_dp_v", bus.dp_v, 0);
    check("rst_ev_valid", bus.ev_valid, 0);
    check("rst_flags", {tick_miss, ev_drop}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      cfg_we = 1'b1; cfg_idx = IDX_W'(i); cfg_b = 8'(5 + i);
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
    en = 1'b1;

    for (int i = 0; i < 8; i++) run_sweep(tbl[i]);

    // Asynchronous reset while the datapath is outstanding.
    lat = 10;
    mask = '0;
    wait_start(ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_in_wait", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_dp_start", bus.dp_start, 0);
    check("arst_dp_v", bus.dp_v, 0);
    check("arst_dp_b", bus.dp_b, 0);
    check("arst_ev", {bus.ev_valid, bus.ev_idx}, 0);
    check("arst_flags", {tick_miss, ev_drop}, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    run_sweep(tbl[8]);
    repeat (10) @(posedge clk);
    #1;
    check("ev_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
`default_nettype wire
